// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer
// -------------------
// Iterative AES-128 controller that drives one shared combinational round
// unit through a full encrypt or decrypt. It performs the initial
// AddRoundKey and then ten round passes. On each pass it requests the
// matching round key from an asynchronous-read key store.
//
// Build option:
//   AES_SEQ_PIPE_EN  When defined, rd_result is registered and every round
//                    pass takes two cycles (issue, then capture). done moves
//                    from cycle 12 to cycle 22. Results are identical in
//                    both builds.
//
// Timing in the default build: start is sampled in IDLE (cycle 0), INIT is
// cycle 1, ROUND r is cycle 1+r, and DONE is cycle 12.

module aes_round_sequencer (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic         encrypt,
    input  logic [127:0] data_in,
    output logic         busy,
    output logic         done,
    output logic [127:0] data_out,
    output logic [3:0]   key_idx,
    input  logic [127:0] key_in,
    output logic [127:0] rd_state,
    output logic [127:0] rd_key,
    output logic         rd_encrypt,
    output logic         rd_last,
    input  logic [127:0] rd_result
);

    // Controller states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_INIT  = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Index of the final round and of the last round key
    localparam logic [3:0] LAST_ROUND = 4'd10;

    logic [1:0]   fsm_q;
    logic [3:0]   round_q;
    logic [127:0] block_q;
    logic         dir_q;
    logic [127:0] data_out_q;

    // High on the cycle whose edge commits a new value into the block register
    logic         round_commit;
    // Value committed into the block register at the end of a round pass
    logic [127:0] round_value;

`ifdef AES_SEQ_PIPE_EN
    // phase_q = 0: issue cycle, round unit output is captured into result_q
    // phase_q = 1: capture cycle, result_q is committed to the block register
    logic         phase_q;
    logic [127:0] result_q;

    // The round pass completes on the capture cycle, using the registered result
    always_comb begin
        round_commit = (fsm_q == ST_ROUND) && phase_q;
        round_value  = result_q;
    end

    // Issue/capture phase toggle and the registered copy of the round output
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            phase_q  <= 1'b0;
            result_q <= '0;
        end else if (fsm_q == ST_ROUND) begin
            phase_q <= ~phase_q;
            if (!phase_q) begin
                result_q <= rd_result;
            end
        end else begin
            phase_q <= 1'b0;
        end
    end
`else
    // Every ROUND cycle completes a pass directly from the round unit output
    always_comb begin
        round_commit = (fsm_q == ST_ROUND);
        round_value  = rd_result;
    end
`endif

    // State sequencing IDLE -> INIT -> ROUND x10 -> DONE -> IDLE
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fsm_q <= ST_IDLE;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (start) begin
                        fsm_q <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    fsm_q <= ST_ROUND;
                end
                ST_ROUND: begin
                    if (round_commit && (round_q == LAST_ROUND)) begin
                        fsm_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    fsm_q <= ST_IDLE;
                end
                default: begin
                    fsm_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Round counter: 0 at start, 1 after INIT, advances per pass and stops at 10
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            round_q <= 4'd0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (start) begin
                        round_q <= 4'd0;
                    end
                end
                ST_INIT: begin
                    round_q <= 4'd1;
                end
                ST_ROUND: begin
                    if (round_commit && (round_q != LAST_ROUND)) begin
                        round_q <= round_q + 4'd1;
                    end
                end
                default: begin
                    round_q <= round_q;
                end
            endcase
        end
    end

    // Block state register: load input, whiten with first key, then take each round result
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            block_q <= '0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (start) begin
                        block_q <= data_in;
                    end
                end
                ST_INIT: begin
                    block_q <= block_q ^ key_in;
                end
                ST_ROUND: begin
                    if (round_commit) begin
                        block_q <= round_value;
                    end
                end
                default: begin
                    block_q <= block_q;
                end
            endcase
        end
    end

    // Direction is captured only when an operation is accepted
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dir_q <= 1'b0;
        end else if ((fsm_q == ST_IDLE) && start) begin
            dir_q <= encrypt;
        end
    end

    // Result register updates only on the final round pass and holds otherwise
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_out_q <= '0;
        end else if (round_commit && (round_q == LAST_ROUND)) begin
            data_out_q <= round_value;
        end
    end

    // Round-key index: ascending for encrypt, descending for decrypt, 0 when idle
    always_comb begin
        key_idx = 4'd0;
        case (fsm_q)
            ST_INIT: begin
                key_idx = dir_q ? 4'd0 : LAST_ROUND;
            end
            ST_ROUND: begin
                key_idx = dir_q ? round_q : (LAST_ROUND - round_q);
            end
            default: begin
                key_idx = 4'd0;
            end
        endcase
    end

    // Status flags and round-unit drive derived from state and registers
    always_comb begin
        busy       = (fsm_q != ST_IDLE);
        done       = (fsm_q == ST_DONE);
        rd_last    = (fsm_q == ST_ROUND) && (round_q == LAST_ROUND);
        rd_state   = block_q;
        rd_key     = key_in;
        rd_encrypt = dir_q;
        data_out   = data_out_q;
    end

endmodule
